// File: rtl/uart_tx_word.sv
// ----------------------------------------------------------------------------
// uart_tx_word
//
// Serial transmitter that drains 16-bit words from the UART Fifo and puts each
// word on the line as 8N1 frames: the low byte first, then (when SEND_HIGH=1)
// the high byte right behind it with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit(s), giving 8E1 / 8E2 frames.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   fifoEmpty  Fifo empty flag
//   readReq    read request to the Fifo, held until readAck
//   readAck    Fifo acknowledge, dataIn valid in the same cycle
//   dataIn     16-bit word from the Fifo
//   txd        serial output, idle high, driven straight from a flop
//   busy       high from the word request until the last stop bit ends
// ----------------------------------------------------------------------------
module uart_tx_word #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SEND_HIGH    = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fifoEmpty,
   output logic        readReq,
   input  logic        readAck,
   input  logic [15:0] dataIn,
   output logic        txd,
   output logic        busy
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   shift_q, shift_d;
   logic          byteSel_q, byteSel_d;
   logic [2:0]    bitIdx_q, bitIdx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stopIdx_q, stopIdx_d;
   logic          txd_q, txd_d;
   logic          readReq_q, readReq_d;
   logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   logic          bitEnd;

   // The current bit period finishes in the cycle the down-counter hits zero.
   assign bitEnd = (cnt_q == '0);

   // State and datapath registers. Reset drops the word in flight and
   // returns the line to idle immediately, even in the middle of a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         byteSel_q <= 1'b0;
         bitIdx_q  <= '0;
         cnt_q     <= '0;
         stopIdx_q <= 1'b0;
         txd_q     <= 1'b1;
         readReq_q <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         byteSel_q <= byteSel_d;
         bitIdx_q  <= bitIdx_d;
         cnt_q     <= cnt_d;
         stopIdx_q <= stopIdx_d;
         txd_q     <= txd_d;
         readReq_q <= readReq_d;
         busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Next-state logic. txd_d is the line level for the *next* cycle, so the
   // pin only ever sees a flop output. Data bits leave from shift_q[0]; after
   // the eight shifts of the low byte the high byte sits in shift_q[7:0].
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      byteSel_d = byteSel_q;
      bitIdx_d  = bitIdx_q;
      cnt_d     = cnt_q;
      stopIdx_d = stopIdx_q;
      txd_d     = txd_q;
      readReq_d = readReq_q;
      busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (!fifoEmpty) begin
               state_d   = REQ;
               readReq_d = 1'b1;
               busy_d    = 1'b1;
            end
         end

         REQ: begin
            if (readAck) begin
               shift_d   = dataIn;
               readReq_d = 1'b0;
               byteSel_d = 1'b0;
               bitIdx_d  = '0;
               cnt_d     = CNT_LOAD;
               txd_d     = 1'b0;
               state_d   = START;
            end
         end

         START: begin
            if (!bitEnd) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               cnt_d    = CNT_LOAD;
               bitIdx_d = '0;
               txd_d    = shift_q[0];
`ifdef UART_TX_PARITY_EN
               parity_d = 1'b0;
`endif
               state_d  = DATA;
            end
         end

         DATA: begin
            if (!bitEnd) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               cnt_d    = CNT_LOAD;
               shift_d  = {1'b0, shift_q[15:1]};
               bitIdx_d = bitIdx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
               parity_d = parity_q ^ shift_q[0];
`endif
               if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  txd_d   = parity_q ^ shift_q[0];
                  state_d = PARITY;
`else
                  txd_d     = 1'b1;
                  stopIdx_d = 1'b0;
                  state_d   = STOP;
`endif
               end else begin
                  txd_d = shift_q[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (!bitEnd) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               cnt_d     = CNT_LOAD;
               txd_d     = 1'b1;
               stopIdx_d = 1'b0;
               state_d   = STOP;
            end
         end
`endif

         STOP: begin
            if (!bitEnd) begin
               cnt_d = cnt_q - CW'(1);
            end else if (STOP_BITS > 1 && !stopIdx_q) begin
               stopIdx_d = 1'b1;
               cnt_d     = CNT_LOAD;
            end else if (!byteSel_q && SEND_HIGH == 1) begin
               byteSel_d = 1'b1;
               cnt_d     = CNT_LOAD;
               txd_d     = 1'b0;
               state_d   = START;
            end else begin
               busy_d  = 1'b0;
               txd_d   = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign txd     = txd_q;
   assign readReq = readReq_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_word
//
// Bench for uart_tx_word at CLKS_PER_BIT=4. A small Fifo model answers
// readReq, a line receiver decodes every frame on txd and compares it with
// the bytes queued when each word was handed to the Fifo, and a table of
// words drives a cycle-exact check of the txd waveform. Building with
// UART_TX_PARITY_EN switches the DUT to SEND_HIGH=0 and 8E1 framing.
// ----------------------------------------------------------------------------
module tb_uart_tx_word;

   localparam int CPB     = 4;
   localparam int TB_STOP = 1;
`ifdef UART_TX_PARITY_EN
   localparam int TB_SEND_HIGH = 0;
   localparam int PAR_BITS     = 1;
`else
   localparam int TB_SEND_HIGH = 1;
   localparam int PAR_BITS     = 0;
`endif

   logic        clk       = 1'b0;
   logic        rst       = 1'b0;
   logic        fifoEmpty = 1'b1;
   logic        readAck   = 1'b0;
   logic [15:0] dataIn    = '0;
   logic        readReq;
   logic        txd;
   logic        busy;

   int          errors  = 0;
   int          checks  = 0;
   logic [15:0] fifoQ[$];
   logic [7:0]  expQ[$];
   logic        pat[$];
   int          ackDelay = 0;
   int          waitCnt  = 0;
   bit          monEn    = 1'b0;

   typedef struct {
      logic [15:0] word;
      int          ackDelay;
      logic [7:0]  expLo;
      logic [7:0]  expHi;
   } vec_t;

   vec_t vectors[6];

   uart_tx_word #(
      .CLKS_PER_BIT(CPB),
      .SEND_HIGH   (TB_SEND_HIGH),
      .STOP_BITS   (TB_STOP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .fifoEmpty(fifoEmpty),
      .readReq  (readReq),
      .readAck  (readAck),
      .dataIn   (dataIn),
      .txd      (txd),
      .busy     (busy)
   );

   // 100 MHz-style clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Hard stop in case something upstream never lets go.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   // Compare one value and keep the running counts.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Expected line levels of one frame, one entry per bit period.
   function automatic void addFrame(input logic [7:0] b);
      pat.push_back(1'b0);
      for (int i = 0; i < 8; i++) pat.push_back(b[i]);
      if (PAR_BITS == 1) pat.push_back(^b);
      for (int s = 0; s < TB_STOP; s++) pat.push_back(1'b1);
   endfunction

   // Fifo model: acknowledges a pending request after ackDelay withheld
   // cycles and presents the next word in the same cycle as readAck.
   always @(negedge clk) begin
      readAck = 1'b0;
      if (!rst) begin
         waitCnt = 0;
      end else if (readReq && fifoQ.size() > 0) begin
         waitCnt++;
         if (waitCnt > ackDelay) begin
            readAck = 1'b1;
            dataIn  = fifoQ.pop_front();
            waitCnt = 0;
         end
      end
      fifoEmpty = (fifoQ.size() == 0);
   end

   // Line receiver: finds each start bit, samples the first cycle of every
   // following bit and checks the byte against the scoreboard queue. A frame
   // cut short by reset or by disabling the monitor is dropped.
   always begin : rxMonitor
      logic [7:0] rxByte;
      logic [7:0] expByte;
      logic       rxPar;
      logic       rxStop;
      bit         aborted;
      @(negedge clk);
      if (monEn && rst === 1'b1 && txd === 1'b0) begin
         aborted = 1'b0;
         rxByte  = '0;
         rxPar   = 1'b0;
         rxStop  = 1'b0;
         for (int i = 1; i <= 9 + PAR_BITS; i++) begin
            repeat (CPB) @(negedge clk);
            if (!monEn || rst !== 1'b1) aborted = 1'b1;
            if (i <= 8) rxByte[i-1] = txd;
            else if (PAR_BITS == 1 && i == 9) rxPar = txd;
            else rxStop = txd;
         end
         if (!aborted) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL rxUnexpected: got byte %0h, expected no frame", rxByte);
            end else begin
               expByte = expQ.pop_front();
               checkOutput("rxByte", rxByte, expByte);
               checkOutput("rxStop", rxStop, 1'b1);
               if (PAR_BITS == 1) checkOutput("rxParity", rxPar, ^expByte);
            end
         end
      end
   end

   // Hand one word to the Fifo and follow it cycle by cycle: request timing,
   // ack latency, the full txd waveform and busy dropping at the end.
   task automatic applyStimulus(input logic [15:0] w, input int dly,
                                input logic [7:0] lo, input logic [7:0] hi);
      int lat;
      int bad;
      int firstBad;
      pat.delete();
      addFrame(lo);
      if (TB_SEND_HIGH == 1) addFrame(hi);
      @(posedge clk);
      #2;
      ackDelay = dly;
      fifoQ.push_back(w);
      expQ.push_back(lo);
      if (TB_SEND_HIGH == 1) expQ.push_back(hi);

      @(negedge clk);
      checkOutput("reqBeforeEdge", {readReq, busy}, 2'b00);
      @(negedge clk);
      checkOutput("reqRise", {readReq, busy}, 2'b11);

      lat = 0;
      bad = 0;
      while (txd === 1'b1 && lat < 200) begin
         if (readReq !== 1'b1 || busy !== 1'b1) bad++;
         @(negedge clk);
         lat++;
      end
      checkOutput("ackLatency", lat, dly + 1);
      checkOutput("reqHeld", bad, 0);
      checkOutput("reqDrop", readReq, 1'b0);

      bad      = 0;
      firstBad = -1;
      for (int k = 0; k < pat.size() * CPB; k++) begin
         if (txd !== pat[k / CPB] || busy !== 1'b1 || readReq !== 1'b0) begin
            bad++;
            if (firstBad < 0) firstBad = k;
         end
         @(negedge clk);
      end
      if (bad != 0) $display("[TB] word %0h: first bad cycle %0d", w, firstBad);
      checkOutput("txdPattern", bad, 0);
      checkOutput("busyFall", {busy, txd, readReq}, 3'b010);
   endtask

   // Wait for busy to reach a level, bounded so a stuck DUT still finishes.
   task automatic waitBusy(input logic level, input string name);
      int n;
      n = 0;
      while (busy !== level && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, busy, level);
   endtask

   // Main sequence: reset idle, table of single words, back-to-back words,
   // then a reset in the middle of a frame.
   initial begin
      int bad;
      int n;

      vectors[0] = '{16'h00a5, 0, 8'ha5, 8'h00};
      vectors[1] = '{16'h1234, 7, 8'h34, 8'h12};
      vectors[2] = '{16'habcd, 2, 8'hcd, 8'hab};
      vectors[3] = '{16'hffff, 0, 8'hff, 8'hff};
      vectors[4] = '{16'h0001, 1, 8'h01, 8'h00};
      vectors[5] = '{16'h8000, 3, 8'h00, 8'h80};

      repeat (5) @(negedge clk);
      checkOutput("resetState", {txd, readReq, busy}, 3'b100);
      rst = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (txd !== 1'b1 || readReq !== 1'b0 || busy !== 1'b0) bad++;
      end
      checkOutput("idleAfterReset", bad, 0);
      monEn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vectors[i].word, vectors[i].ackDelay,
                       vectors[i].expLo, vectors[i].expHi);
         repeat (3) @(negedge clk);
      end

      // Two words queued at once: one idle cycle then one request cycle.
      @(posedge clk);
      #2;
      ackDelay = 0;
      fifoQ.push_back(16'h1234);
      fifoQ.push_back(16'habcd);
      expQ.push_back(8'h34);
      if (TB_SEND_HIGH == 1) expQ.push_back(8'h12);
      expQ.push_back(8'hcd);
      if (TB_SEND_HIGH == 1) expQ.push_back(8'hab);
      waitBusy(1'b1, "b2bFirstBusy");
      waitBusy(1'b0, "b2bFirstDone");
      n = 0;
      while (busy === 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b2bIdleCycles", n, 1);
      checkOutput("b2bReqSecond", readReq, 1'b1);
      n = 0;
      while (txd === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b2bAckCycles", n, 1);
      bad = 0;
      n   = 0;
      while (busy === 1'b1 && n < 5000) begin
         if (readReq !== 1'b0) bad++;
         @(negedge clk);
         n++;
      end
      checkOutput("b2bNoReqWhileSending", bad, 0);
      checkOutput("b2bDone", busy, 1'b0);
      repeat (20) @(negedge clk);

      // Reset during bit 3 of the low byte of 16'hffff.
      monEn = 1'b0;
      @(posedge clk);
      #2;
      ackDelay = 0;
      fifoQ.push_back(16'hffff);
      n = 0;
      while (txd !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midStartSeen", txd, 1'b0);
      repeat (4 + 3 * CPB + 1) @(negedge clk);
      checkOutput("midInBit3", {txd, busy}, 2'b11);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("midResetAsync", {txd, readReq, busy}, 3'b100);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (txd !== 1'b1 || readReq !== 1'b0 || busy !== 1'b0) bad++;
      end
      checkOutput("midIdleAfterRelease", bad, 0);
      monEn = 1'b1;

      repeat (20) @(negedge clk);
      checkOutput("scoreboardEmpty", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- Serial transmitter stage that sits directly downstream of the UART Fifo.
- Pulls 16-bit words from the Fifo read port using the readReq/readAck handshake.
- Sends each word on txd as two 8N1 UART frames: low byte first, then high byte (high byte optional via parameter).
- Owns the only path from the Fifo to the pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2
SEND_HIGH, 1, 1 = send both bytes of each word; 0 = send low byte only, high byte discarded
STOP_BITS, 1, number of stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
fifoEmpty  input  1  Fifo empty flag
readReq  output  1  read request to Fifo
readAck  input  1  Fifo read acknowledge; dataIn valid in the same cycle
dataIn  input  16  word from Fifo dataOut
txd  output  1  serial line, idle high
busy  output  1  high from word request until last stop bit of the word ends

Behaviour:
- Reset (rst=0, asynchronous): txd=1, readReq=0, busy=0, state=IDLE, all counters 0. Takes effect immediately, including mid-frame; the word in flight is discarded and not re-fetched.
- States: IDLE, REQ, START, DATA, [PARITY], STOP.
- IDLE:
  - fifoEmpty=0 -> REQ on next edge; readReq=1 and busy=1 from that edge.
  - fifoEmpty=1 -> stay IDLE; readReq=0, txd=1.
- REQ:
  - readReq held high until readAck=1; no timeout.
  - On an edge with readAck=1: latch dataIn into a 16-bit shift register, readReq=0 at that edge, byteSel=0, go to START.
  - fifoEmpty is ignored while in REQ.
- START: txd=0 for exactly CLKS_PER_BIT cycles -> DATA.
- DATA:
  - 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles.
  - Byte is dataIn[7:0] when byteSel=0, dataIn[15:8] when byteSel=1.
  - Then -> PARITY if compiled in, else -> STOP.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then:
  - byteSel=0 and SEND_HIGH=1 -> byteSel=1, go to START directly (no idle gap).
  - Otherwise -> IDLE, busy=0 on the same edge.
- Back-to-back words: IDLE lasts exactly one cycle before REQ when fifoEmpty=0. The minimum gap between words is therefore 1 idle cycle plus the ack latency.
- Bit timing:
  - Down-counter of width $clog2(CLKS_PER_BIT), loaded with CLKS_PER_BIT-1 on every bit entry; bit advances when the counter reaches 0.
  - The bit index counter wraps 7 -> 0 on the DATA exit.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- txd is driven from a register (glitch-free); combinational decode must not reach the pin.
- readAck seen outside REQ is ignored.
- dataIn is sampled only on the REQ/readAck edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1 (or 8E2 with STOP_BITS=2).
- Undefined:
  - No PARITY state and no parity logic; frame is 8N1/8N2.

Test Plan:
- Reset idle: rst=0 for 5 cycles, then rst=1 with fifoEmpty=1 for 200 cycles -> txd=1, readReq=0, busy=0 throughout.
- Single word, CLKS_PER_BIT=4, SEND_HIGH=1:
  - Fifo holds 16'h00a5.
  - readReq rises 1 cycle after fifoEmpty falls and drops on the readAck edge.
  - txd sequence at 4 clk/bit: 0,1,0,1,0,0,1,0,1,1 (0xa5), then 0,0,0,0,0,0,0,0,0,1 (0x00).
  - busy high for 80 cycles plus request latency.
- Delayed ack: readAck withheld 7 cycles -> readReq stays 1 for all 7 cycles, txd stays 1; first start bit in the cycle after the ack edge.
- Back-to-back: Fifo holds 16'h1234 then 16'habcd.
  - Bytes on line: 34, 12, cd, ab.
  - Exactly one idle cycle plus ack latency between words.
  - No readReq while busy sending.
- Reset mid-frame: rst=0 during bit 3 of low byte of 16'hffff -> txd=1 and readReq=0 within the reset cycle; after release with fifoEmpty=1 the line stays idle.
- With UART_TX_PARITY_EN and SEND_HIGH=0:
  - Word 16'h0001 -> parity bit 1.
  - Word 16'h00a5 -> parity bit 0.
  - Frame is 11 bits = 44 cycles at CLKS_PER_BIT=4.
